// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring decoder.
// The helper functions work on a MAX_WIDTH-wide vector; callers zero-extend narrower rings.
package ring_pkg;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } ring_state_e;

  localparam int unsigned MAX_WIDTH      = 32;
  localparam int unsigned MAX_IDXW       = 5;
  // Index the matching ring counter holds out of reset (pattern ...0001)
  localparam int unsigned RING_RESET_IDX = 0;

  function automatic logic is_onehot(input logic [MAX_WIDTH-1:0] vec);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      ones = ones + {31'd0, vec[i]};
    end
    return (ones == 1);
  endfunction

  function automatic logic [MAX_IDXW-1:0] onehot_to_idx(input logic [MAX_WIDTH-1:0] vec);
    logic [MAX_IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (vec[i]) begin
        idx = idx | MAX_IDXW'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot to binary encoder with an exactly-one-bit-set flag.
// idx_o is only meaningful when onehot_o is high.
module ring_onehot_enc
  import ring_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDXW-1:0]  idx_o,
  output logic             onehot_o
);

  logic [MAX_WIDTH-1:0] wideVec;

  always_comb begin
    wideVec             = '0;
    wideVec[WIDTH-1:0]  = vec_i;
  end

  assign idx_o    = IDXW'(onehot_to_idx(wideVec));
  assign onehot_o = is_onehot(wideVec);

endmodule

// File: rtl/ring_decoder.sv
// Receive-side decoder/monitor for a left-rotating one-hot ring counter (WIDTH <= 32).
// Optional macro RING_DECODER_ERRCNT_EN adds a saturating 16-bit err_count output.
module ring_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int IDXW     = $clog2(WIDTH),
  parameter int LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ring_in,
  output logic [IDXW-1:0]  idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             wrap
`ifdef RING_DECODER_ERRCNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  localparam int            CNTW     = $clog2(LOCK_CNT + 1);
  localparam logic [CNTW:0] LOCK_TGT = (CNTW + 1)'(LOCK_CNT);

  ring_state_e     state_q, state_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            idxValid_q, idxValid_d;
  logic            onehotErr_q, onehotErr_d;
  logic            seqErr_q, seqErr_d;
  logic            wrap_q, wrap_d;

  logic [IDXW-1:0] encIdx;
  logic            encOnehot;
  logic [IDXW-1:0] nextIdx;
  logic            isSucc;
  logic            atTop;

  ring_onehot_enc #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_enc (
    .vec_i    (ring_in),
    .idx_o    (encIdx),
    .onehot_o (encOnehot)
  );

  // Wrap at WIDTH-1 explicitly so non-power-of-two rings never visit unused codes
  assign atTop   = (idx_q == IDXW'(WIDTH - 1));
  assign nextIdx = atTop ? '0 : idx_q + 1'b1;
  assign isSucc  = (encIdx == nextIdx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      count_q     <= '0;
      idx_q       <= IDXW'(RING_RESET_IDX);
      idxValid_q  <= 1'b0;
      onehotErr_q <= 1'b0;
      seqErr_q    <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      idxValid_q  <= idxValid_d;
      onehotErr_q <= onehotErr_d;
      seqErr_q    <= seqErr_d;
      wrap_q      <= wrap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    idxValid_d  = 1'b0;
    onehotErr_d = 1'b0;
    seqErr_d    = 1'b0;
    wrap_d      = 1'b0;

    if (in_valid) begin
      if (!encOnehot) begin
        // A corrupt vector loses all sequence confidence; idx keeps the last good value
        onehotErr_d = 1'b1;
        state_d     = HUNT;
        count_d     = '0;
      end else begin
        idx_d      = encIdx;
        idxValid_d = 1'b1;
        unique case (state_q)
          HUNT: begin
            count_d = '0;
            state_d = CHECK;
          end
          CHECK: begin
            if (isSucc) begin
              if (({1'b0, count_q} + 1'b1) == LOCK_TGT) begin
                state_d = LOCKED;
                count_d = '0;
              end else begin
                count_d = count_q + 1'b1;
              end
            end else begin
              seqErr_d = 1'b1;
              count_d  = '0;
            end
          end
          LOCKED: begin
            if (isSucc) begin
              wrap_d = atTop && (encIdx == '0);
            end else begin
              seqErr_d = 1'b1;
              count_d  = '0;
              state_d  = CHECK;
            end
          end
          default: begin
            state_d = HUNT;
            count_d = '0;
          end
        endcase
      end
    end
  end

  assign idx        = idx_q;
  assign idx_valid  = idxValid_q;
  assign locked     = (state_q == LOCKED);
  assign onehot_err = onehotErr_q;
  assign seq_err    = seqErr_q;
  assign wrap       = wrap_q;

`ifdef RING_DECODER_ERRCNT_EN
  logic [15:0] errCount_q;

  // Counts on the next-state pulses so err_count moves in the same cycle the pulse appears
  always_ff @(posedge clk) begin
    if (reset) begin
      errCount_q <= '0;
    end else if ((onehotErr_d || seqErr_d) && (errCount_q != 16'hFFFF)) begin
      errCount_q <= errCount_q + 16'd1;
    end
  end

  assign err_count = errCount_q;
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// Scoreboard bench for ring_decoder: directed scenarios plus randomized traffic.
// Define RING_DECODER_ERRCNT_EN to also exercise the error counter.
module tb_ring_decoder;

  localparam int WIDTH    = 4;
  localparam int LOCK_CNT = 2;
  localparam int IDXW     = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             inValid = 1'b0;
  logic [WIDTH-1:0] ringIn = '0;
  logic [IDXW-1:0]  idx;
  logic             idxValid, locked, onehotErr, seqErr, wrap;
  logic [15:0]      errCountObs;

  always #5 clk = ~clk;

`ifdef RING_DECODER_ERRCNT_EN
  logic [15:0] errCount;
  assign errCountObs = errCount;
`else
  assign errCountObs = 16'd0;
`endif

  ring_decoder #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (inValid),
    .ring_in    (ringIn),
    .idx        (idx),
    .idx_valid  (idxValid),
    .locked     (locked),
    .onehot_err (onehotErr),
    .seq_err    (seqErr),
    .wrap       (wrap)
`ifdef RING_DECODER_ERRCNT_EN
    ,
    .err_count  (errCount)
`endif
  );

  typedef struct {
    logic [IDXW-1:0] idx;
    logic            idxValid;
    logic            locked;
    logic            onehotErr;
    logic            seqErr;
    logic            wrap;
    logic [15:0]     errCount;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a chain of consecutive successor steps since the last reference capture
  bit mHasRef = 0;
  int mLast   = 0;
  int mRun    = 0;
  int mErr    = 0;

  task automatic applyStimulus(input logic rst, input logic v, input logic [WIDTH-1:0] vec);
    exp_t e;
    bit   wasLocked;
    int   n;
    @(negedge clk);
    reset   = rst;
    inValid = v;
    ringIn  = vec;
    e.idxValid  = 1'b0;
    e.onehotErr = 1'b0;
    e.seqErr    = 1'b0;
    e.wrap      = 1'b0;
    if (rst) begin
      mHasRef = 0;
      mLast   = 0;
      mRun    = 0;
      mErr    = 0;
    end else if (v) begin
      wasLocked = mHasRef && (mRun >= LOCK_CNT);
      if ($countones(vec) != 1) begin
        e.onehotErr = 1'b1;
        mHasRef     = 0;
        mRun        = 0;
      end else begin
        n = $clog2(vec);
        e.idxValid = 1'b1;
        if (!mHasRef) begin
          mHasRef = 1;
          mRun    = 0;
        end else if (n == (mLast + 1) % WIDTH) begin
          mRun++;
          e.wrap = wasLocked && (mLast == WIDTH - 1) && (n == 0);
        end else begin
          e.seqErr = 1'b1;
          mRun     = 0;
        end
        mLast = n;
      end
      if ((e.onehotErr || e.seqErr) && mErr < 65535) mErr++;
    end
    e.locked   = mHasRef && (mRun >= LOCK_CNT);
    e.idx      = IDXW'(mLast);
`ifdef RING_DECODER_ERRCNT_EN
    e.errCount = 16'(mErr);
`else
    e.errCount = 16'd0;
`endif
    expQ.push_back(e);
  endtask

  task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("idx", 16'(idx), 16'(e.idx));
    checkField("idx_valid", 16'(idxValid), 16'(e.idxValid));
    checkField("locked", 16'(locked), 16'(e.locked));
    checkField("onehot_err", 16'(onehotErr), 16'(e.onehotErr));
    checkField("seq_err", 16'(seqErr), 16'(e.seqErr));
    checkField("wrap", 16'(wrap), 16'(e.wrap));
`ifdef RING_DECODER_ERRCNT_EN
    checkField("err_count", errCountObs, e.errCount);
`endif
  endtask

  // Monitor: each active edge produces one registered response, compared 1 time unit later
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    int r;
    logic [WIDTH-1:0] vec;

    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);

    // Lock-in, wrap, corrupt vectors, sequence break, relock, reset mid-lock
    applyStimulus(1'b0, 1'b1, 4'b0001);
    applyStimulus(1'b0, 1'b1, 4'b0010);
    applyStimulus(1'b0, 1'b1, 4'b0100);
    applyStimulus(1'b0, 1'b0, 4'b1111);
    applyStimulus(1'b0, 1'b1, 4'b1000);
    applyStimulus(1'b0, 1'b1, 4'b0001);
    applyStimulus(1'b0, 1'b1, 4'b0010);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b0110);
    applyStimulus(1'b0, 1'b1, 4'b0001);
    applyStimulus(1'b0, 1'b1, 4'b0010);
    applyStimulus(1'b0, 1'b1, 4'b0100);
    applyStimulus(1'b0, 1'b1, 4'b0001);
    applyStimulus(1'b0, 1'b1, 4'b0010);
    applyStimulus(1'b0, 1'b1, 4'b0100);
    applyStimulus(1'b0, 1'b1, 4'b0100);
    applyStimulus(1'b0, 1'b1, 4'b1000);
    applyStimulus(1'b0, 1'b1, 4'b0001);
    applyStimulus(1'b1, 1'b1, 4'b0010);
    applyStimulus(1'b0, 1'b1, 4'b0100);
    applyStimulus(1'b0, 1'b1, 4'b1000);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 19);
      vec = WIDTH'($urandom);
      if (r == 0) begin
        applyStimulus(1'b1, 1'b0, vec);
      end else if (r <= 2) begin
        applyStimulus(1'b0, 1'b0, vec);
      end else if (r == 3) begin
        applyStimulus(1'b0, 1'b1, '0);
      end else if (r == 4) begin
        applyStimulus(1'b0, 1'b1, vec);
      end else if (r <= 6) begin
        applyStimulus(1'b0, 1'b1, WIDTH'(1 << $urandom_range(0, WIDTH - 1)));
      end else begin
        applyStimulus(1'b0, 1'b1, WIDTH'(1 << ((mLast + 1) % WIDTH)));
      end
    end

`ifdef RING_DECODER_ERRCNT_EN
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b0011);
    applyStimulus(1'b0, 1'b1, 4'b1111);
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(1'b0, 1'b1, 4'b0000);
    end
`endif

    applyStimulus(1'b0, 1'b0, '0);
    @(posedge clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
